pingpong_wr_ctrl: RTL and testbench

//  Upstream feeder of the ping-pong RAM bank switcher (change_ram/ram_busy -> ram_adj/ram_change).

---
 rtl/pingpong_wr_ctrl.sv | 129 ++++++++++++
 tb/tb_pingpong_wr_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_wr_ctrl.sv
// Byte-stream writer for one half of a ping-pong RAM. It fills the bank given by
// ram_adj, then requests a bank swap and reports the filled bank to the program engine.
module pingpong_wr_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11,
  parameter int PAGE_BYTES = 2048,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              ram_adj,
  input  logic              ram_change,
  output logic              change_ram,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              page_done,
  output logic              done_bank,
  output logic              swap_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] WLAST = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [ADDR_W-1:0] WONE  = 1;
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TONE  = 1;

  typedef enum logic {FILL, REQ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                cur_bank_q, cur_bank_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                chg_q, chg_d;
  logic                pd_q, pd_d;
  logic                db_q, db_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      cur_bank_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      chg_q      <= 1'b0;
      pd_q       <= 1'b0;
      db_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      cur_bank_q <= cur_bank_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      chg_q      <= chg_d;
      pd_q       <= pd_d;
      db_q       <= db_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    cur_bank_d = cur_bank_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    chg_d      = chg_q;
    pd_d       = 1'b0;
    db_d       = db_q;
    err_d      = err_q;
    case (state_q)
      FILL: begin
        // ram_change is deliberately ignored here (e.g. the switcher's post-reset pulse)
        if (din_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = din;
          wr_addr_d = {cur_bank_q, wcnt_q};
          if (wcnt_q == WLAST) begin
            wcnt_d  = '0;
            chg_d   = 1'b1;
            tcnt_d  = '0;
            state_d = REQ;
          end else begin
            wcnt_d = wcnt_q + WONE;
          end
        end
      end
      REQ: begin
        if (ram_change) begin
          chg_d      = 1'b0;
          pd_d       = 1'b1;
          db_d       = cur_bank_q;
          cur_bank_d = ram_adj;
          state_d    = FILL;
        end else if (tcnt_q == TLAST) begin
          // saturate so the request keeps being held without wrapping the counter
          err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TONE;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign din_ready  = (state_q == FILL);
  assign change_ram = chg_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign page_done  = pd_q;
  assign done_bank  = db_q;
  assign swap_err   = err_q;

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Randomized bench for pingpong_wr_ctrl: a page-level reference model predicts every
// output each cycle, plus spot checks of the fixed scenarios against literal values.
module tb_pingpong_wr_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 11;
  localparam int PAGE   = 2048;
  localparam int TOUT   = 1024;
  localparam int VW     = 3 + (ADDR_W + 1) + DATA_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              ram_adj = 1'b0;
  logic              ram_change = 1'b0;
  logic              din_ready, change_ram, wr_en, page_done, done_bank, swap_err;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  int n_chk = 0;
  int n_fail = 0;
  bit sw_bank = 1'b0;
  logic [VW-1:0] rst_exp;

  always #5 clk = ~clk;

  pingpong_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAGE_BYTES(PAGE), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ram_adj(ram_adj), .ram_change(ram_change), .change_ram(change_ram), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .page_done(page_done), .done_bank(done_bank),
    .swap_err(swap_err)
  );

  // Reference model: bytes-in-page count, active bank, and whether a swap is outstanding.
  bit              m_req, m_bank, m_wr, m_chg, m_pd, m_db, m_err;
  int              m_cnt, m_tout;
  bit [ADDR_W:0]   m_addr;
  bit [DATA_W-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 0; m_bank <= 0; m_wr <= 0; m_chg <= 0; m_pd <= 0; m_db <= 0; m_err <= 0;
      m_cnt <= 0; m_tout <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_wr <= 0;
      m_pd <= 0;
      if (!m_req) begin
        if (din_valid) begin
          m_wr   <= 1;
          m_addr <= (ADDR_W+1)'(m_bank * (2**ADDR_W) + m_cnt);
          m_data <= din;
          if (m_cnt + 1 == PAGE) begin
            m_cnt <= 0; m_req <= 1; m_chg <= 1; m_tout <= 0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end else if (ram_change) begin
        m_pd <= 1; m_db <= m_bank; m_bank <= ram_adj; m_req <= 0; m_chg <= 0;
      end else begin
        m_tout <= m_tout + 1;
        if (m_tout + 1 >= TOUT) m_err <= 1;
      end
    end
  end

  function automatic logic [VW-1:0] obs_vec();
    return {din_ready, change_ram, wr_en, (wr_en ? wr_addr : {(ADDR_W+1){1'b0}}),
            (wr_en ? wr_data : {DATA_W{1'b0}}), page_done, page_done & done_bank, swap_err};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {!m_req, m_chg, m_wr, (m_wr ? m_addr : {(ADDR_W+1){1'b0}}),
            (m_wr ? m_data : {DATA_W{1'b0}}), m_pd, m_pd & m_db, m_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; ram_change = 1'b0; ram_adj = 1'b0; sw_bank = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec() !== rst_exp) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", obs_vec(), rst_exp);
    end
    n_chk++;
    tick();
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec());
    end
    n_chk++;
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fill_page();
    do_reset();
    for (int i = 0; i < PAGE; i++) begin
      din_valid = 1'b1; din = DATA_W'(i % 256);
      tick();
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fill_model[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_chk++;
      if (wr_en !== 1'b1 || wr_addr !== (ADDR_W+1)'(i) || wr_data !== DATA_W'(i % 256)) begin
        n_fail++;
        $display("FAIL fill_write[%0d]: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 i, wr_en, wr_addr, wr_data, i, i % 256);
      end
      n_chk++;
    end
    din_valid = 1'b0;
    if (change_ram !== 1'b1 || din_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_end: got change_ram=%b din_ready=%b want 1 0", change_ram, din_ready);
    end
    n_chk++;
  endtask

  task automatic test_swap();
    int k;
    k = $urandom_range(1, 20);
    for (int i = 0; i < k; i++) begin
      din_valid = 1'($urandom); din = DATA_W'($urandom);
      tick();
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL swap_wait[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_chk++;
    end
    din_valid = 1'b0;
    sw_bank = ~sw_bank; ram_adj = sw_bank; ram_change = 1'b1;
    tick();
    ram_change = 1'b0;
    if (page_done !== 1'b1 || done_bank !== 1'b0 || change_ram !== 1'b0) begin
      n_fail++; $display("FAIL swap_pulse: got pd=%b bank=%b chg=%b want 1 0 0", page_done, done_bank, change_ram);
    end
    n_chk++;
    tick();
    if (page_done !== 1'b0) begin
      n_fail++; $display("FAIL swap_pulse_width: got pd=%b want 0", page_done);
    end
    n_chk++;
    for (int j = 0; j < 16; j++) begin
      din_valid = 1'b1; din = DATA_W'($urandom);
      tick();
      if (obs_vec() !== exp_vec() || wr_addr !== (ADDR_W+1)'(12'h800 + j)) begin
        n_fail++; $display("FAIL swap_next_bank[%0d]: got %h addr=%h want %h addr=%h",
                           j, obs_vec(), wr_addr, exp_vec(), 12'h800 + j);
      end
      n_chk++;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_spurious_change();
    do_reset();
    ram_adj = 1'($urandom); ram_change = 1'b1;
    tick();
    ram_change = 1'b0; ram_adj = 1'b0;
    if (page_done !== 1'b0 || din_ready !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL spurious_change: got %h pd=%b rdy=%b want %h pd=0 rdy=1",
                         obs_vec(), page_done, din_ready, exp_vec());
    end
    n_chk++;
    din_valid = 1'b1; din = DATA_W'($urandom);
    tick();
    din_valid = 1'b0;
    if (wr_en !== 1'b1 || wr_addr !== '0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL spurious_first_addr: got en=%b addr=%h want en=1 addr=000", wr_en, wr_addr);
    end
    n_chk++;
  endtask

  task automatic test_timeout();
    int guard;
    do_reset();
    guard = 0;
    while (!m_req && guard < 10000) begin
      din_valid = ($urandom % 4) != 0; din = DATA_W'($urandom);
      tick();
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL timeout_fill[%0d]: got %h want %h", guard, obs_vec(), exp_vec());
      end
      n_chk++;
      guard++;
    end
    din_valid = 1'b0;
    if (!m_req) begin
      n_fail++; $display("FAIL timeout_fill_bound: got no page end in %0d cycles want %0d accepts", guard, PAGE);
    end
    n_chk++;
    for (int k = 1; k <= TOUT + 20; k++) begin
      din_valid = 1'($urandom);
      tick();
      if (obs_vec() !== exp_vec() || swap_err !== (k >= TOUT)) begin
        n_fail++; $display("FAIL timeout_req[%0d]: got %h err=%b want %h err=%b",
                           k, obs_vec(), swap_err, exp_vec(), k >= TOUT);
      end
      n_chk++;
    end
    din_valid = 1'b0;
    sw_bank = ~sw_bank; ram_adj = sw_bank; ram_change = 1'b1;
    tick();
    ram_change = 1'b0;
    if (page_done !== 1'b1 || done_bank !== 1'b0 || swap_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_late_swap: got pd=%b bank=%b err=%b want 1 0 1", page_done, done_bank, swap_err);
    end
    n_chk++;
    repeat (3) tick();
    if (swap_err !== 1'b1 || din_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b rdy=%b want 1 1", swap_err, din_ready);
    end
    n_chk++;
  endtask

  task automatic test_gapped_valid();
    int cnt;
    logic [ADDR_W:0] prev;
    cnt = 0; prev = '0;
    for (int c = 0; c < 2 * PAGE + 10; c++) begin
      din_valid = (c % 2) == 0; din = DATA_W'($urandom);
      tick();
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL gapped_model[%0d]: got %h want %h", c, obs_vec(), exp_vec());
      end
      n_chk++;
      if (wr_en === 1'b1) begin
        cnt++;
        if ((cnt == 1 && wr_addr !== 12'h800) || (cnt > 1 && wr_addr !== prev + 1'b1)) begin
          n_fail++; $display("FAIL gapped_contig[%0d]: got addr=%h after %h", cnt, wr_addr, prev);
        end
        n_chk++;
        prev = wr_addr;
      end
    end
    din_valid = 1'b0;
    if (cnt !== PAGE) begin
      n_fail++; $display("FAIL gapped_count: got %0d writes want %0d", cnt, PAGE);
    end
    n_chk++;
    sw_bank = ~sw_bank; ram_adj = sw_bank; ram_change = 1'b1;
    tick();
    ram_change = 1'b0;
    if (page_done !== 1'b1 || done_bank !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL gapped_swap: got pd=%b bank=%b want pd=1 bank=1", page_done, done_bank);
    end
    n_chk++;
  endtask

  task automatic test_reset_mid_page();
    for (int i = 0; i < 1000; i++) begin
      din_valid = 1'b1; din = DATA_W'($urandom);
      tick();
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midrst_fill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_chk++;
    end
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec() !== rst_exp) begin
      n_fail++; $display("FAIL midrst_async: got %h want %h", obs_vec(), rst_exp);
    end
    n_chk++;
    din_valid = 1'b0; sw_bank = 1'b0; ram_adj = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    din_valid = 1'b1; din = DATA_W'($urandom);
    tick();
    din_valid = 1'b0;
    if (wr_en !== 1'b1 || wr_addr !== '0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL midrst_restart: got en=%b addr=%h want en=1 addr=000", wr_en, wr_addr);
    end
    n_chk++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_exp = '0;
    rst_exp[VW-1] = 1'b1;
    test_reset();
    test_fill_page();
    test_swap();
    test_spurious_change();
    test_timeout();
    test_gapped_valid();
    test_reset_mid_page();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
